// File: rtl/lvds_ddr_tx.sv
// DDR LVDS transmit word path: 2-entry input FIFO, training/idle insertion, lane bit split.
// Optional PRBS-15 generator in RUN is enabled by defining LVDS_TX_PRBS_EN.
//
// state | meaning
// RST   | held in reset; lanes quiet, forwarded clock off, input not ready
// TRAIN | TRAIN_PATTERN sent every cycle while the down-counter runs to 0
// RUN   | FIFO head (or IDLE_PATTERN when empty) sent every cycle
module lvds_ddr_tx #(
    parameter logic [15:0] TRAIN_PATTERN = 16'hA55A,
    parameter int          TRAIN_CYCLES  = 64,
    parameter logic [15:0] IDLE_PATTERN  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        train_req,
`ifdef LVDS_TX_PRBS_EN
    input  logic        prbs_sel,
`endif
    output logic [7:0]  lane_rise,
    output logic [7:0]  lane_fall,
    output logic        clk_fwd_en,
    output logic        train_done,
    output logic [15:0] underrun_cnt
);

    localparam int CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   word_q, word_d;
    logic [15:0]   underrun_q, underrun_d;
    logic          in_ready_q, in_ready_d;
    logic [15:0]   mem_q [2];
    logic [15:0]   mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push;
    logic          pop;
    logic          load_run;
`ifdef LVDS_TX_PRBS_EN
    localparam logic [14:0] LFSR_SEED = 15'h7FFF;
    logic [14:0]   lfsr_q, lfsr_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        underrun_d = underrun_q;
        load_run   = 1'b0;
        pop        = 1'b0;
`ifdef LVDS_TX_PRBS_EN
        lfsr_d     = lfsr_q;
`endif

        case (state_q)
            ST_RST: begin
                state_d = ST_TRAIN;
                cnt_d   = CNT_LOAD;
                word_d  = TRAIN_PATTERN;
            end
            ST_TRAIN: begin
                word_d = TRAIN_PATTERN;
                if (train_req) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d  = ST_RUN;
                    load_run = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (train_req) begin
                    state_d = ST_TRAIN;
                    cnt_d   = CNT_LOAD;
                    word_d  = TRAIN_PATTERN;
                end else begin
                    load_run = 1'b1;
                end
            end
            default: state_d = ST_RST;
        endcase

        // Payload selection for a RUN word; overrides the TRAIN load on the last TRAIN cycle.
`ifdef LVDS_TX_PRBS_EN
        if (load_run && prbs_sel) begin
            word_d = {1'b0, lfsr_q};
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end else
`endif
        if (load_run) begin
            if (count_q != 2'd0) begin
                pop    = 1'b1;
                word_d = mem_q[rd_ptr_q];
            end else begin
                word_d = IDLE_PATTERN;
                if (underrun_q != 16'hFFFF) begin
                    underrun_d = underrun_q + 16'd1;
                end
            end
        end

`ifdef LVDS_TX_PRBS_EN
        if (state_d != ST_RUN) begin
            lfsr_d = LFSR_SEED;
        end
`endif
    end

    always_comb begin
        push     = in_valid && in_ready_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready is registered from next occupancy, so a full FIFO never sees a write.
        in_ready_d = (state_d != ST_RST) && (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            cnt_q      <= '0;
            word_q     <= 16'h0000;
            underrun_q <= 16'h0000;
            in_ready_q <= 1'b0;
            mem_q[0]   <= 16'h0000;
            mem_q[1]   <= 16'h0000;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            underrun_q <= underrun_d;
            in_ready_q <= in_ready_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef LVDS_TX_PRBS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_rise[gi] = word_q[2*gi];
            assign lane_fall[gi] = word_q[2*gi+1];
        end
    endgenerate

    assign in_ready     = in_ready_q;
    assign clk_fwd_en   = (state_q != ST_RST);
    assign train_done   = (state_q == ST_RUN);
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_lvds_ddr_tx.sv
// Scoreboard bench for lvds_ddr_tx: stimulus queues expected words/train lengths, a monitor checks lanes.
module tb_lvds_ddr_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        train_req = 1'b0;
    logic [7:0]  lane_rise;
    logic [7:0]  lane_fall;
    logic        clk_fwd_en;
    logic        train_done;
    logic [15:0] underrun_cnt;

    lvds_ddr_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .train_req    (train_req),
`ifdef LVDS_TX_PRBS_EN
        .prbs_sel     (1'b0),
`endif
        .lane_rise    (lane_rise),
        .lane_fall    (lane_fall),
        .clk_fwd_en   (clk_fwd_en),
        .train_done   (train_done),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] w;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   train_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic expect_word(input logic [15:0] w, input int c);
        exp_t e;
        e.w = w;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Monitor: rebuild the word from the lanes and classify it as TRAIN, data or idle.
    logic [15:0] mon_w;
    int          run_len = 0;
    bit          prev_td = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                mon_w[2*i]   = lane_rise[i];
                mon_w[2*i+1] = lane_fall[i];
            end
            if (!clk_fwd_en) begin
                run_len = 0;
                prev_td = 1'b0;
            end else if (!train_done) begin
                check("train_word", {16'h0, mon_w}, 32'h0000A55A);
                run_len++;
                prev_td = 1'b0;
            end else begin
                if (!prev_td && run_len > 0) begin
                    int exp_len;
                    exp_len = (train_q.size() > 0) ? train_q.pop_front() : -1;
                    check("train_len", run_len, exp_len);
                    run_len = 0;
                end
                prev_td = 1'b1;
                if (mon_w != 16'h0000) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {16'h0, mon_w}, 32'h0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("data_word", {16'h0, mon_w}, {16'h0, e.w});
                        check("data_cycle", cyc, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        train_q.push_back(64);

        #12;
        check("rst_lane_rise", lane_rise, 8'h00);
        check("rst_lane_fall", lane_fall, 8'h00);
        check("rst_clk_fwd_en", clk_fwd_en, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_train_done", train_done, 1'b0);
        check("rst_underrun", underrun_cnt, 16'h0);

        #18 rst_n = 1'b1;

        // First edge after release: training starts immediately.
        wait_cyc(1);
        check("first_clk_fwd_en", clk_fwd_en, 1'b1);
        check("first_in_ready", in_ready, 1'b1);
        check("first_lane_rise", lane_rise, 8'h3C);
        check("first_lane_fall", lane_fall, 8'hC3);
        wait_cyc(64);
        check("last_train_done", train_done, 1'b0);
        wait_cyc(65);
        check("run_train_done", train_done, 1'b1);
        check("run_idle_rise", lane_rise, 8'h00);
        check("run_idle_fall", lane_fall, 8'h00);
        check("run_underrun_1", underrun_cnt, 16'd1);
        wait_cyc(70);
        check("run_underrun_6", underrun_cnt, 16'd6);

        // Back-to-back stream: each word one cycle after its accept edge, no gaps.
        wait_cyc(80);
        in_valid = 1'b1; in_data = 16'h0001;
        check("stream_ready0", in_ready, 1'b1);
        expect_word(16'h0001, 82);
        wait_cyc(81);
        in_data = 16'hFFFE;
        check("stream_ready1", in_ready, 1'b1);
        expect_word(16'hFFFE, 83);
        wait_cyc(82);
        in_data = 16'h5555;
        check("stream_ready2", in_ready, 1'b1);
        expect_word(16'h5555, 84);
        wait_cyc(83);
        in_valid = 1'b0;
        wait_cyc(84);
        check("stream_lane_rise", lane_rise, 8'hFF);
        check("stream_lane_fall", lane_fall, 8'h00);
        check("stream_underrun", underrun_cnt, 16'd17);

        // Retrain, then fill the FIFO while training: third write must be refused.
        wait_cyc(90);
        train_req = 1'b1;
        train_q.push_back(64);
        wait_cyc(91);
        train_req = 1'b0;
        wait_cyc(92);
        in_valid = 1'b1; in_data = 16'h1234;
        check("fill_ready0", in_ready, 1'b1);
        expect_word(16'h1234, 155);
        wait_cyc(93);
        in_data = 16'h5678;
        check("fill_ready1", in_ready, 1'b1);
        expect_word(16'h5678, 156);
        wait_cyc(94);
        in_data = 16'h9ABC;
        check("fill_full_ready", in_ready, 1'b0);
        wait_cyc(95);
        in_valid = 1'b0;
        wait_cyc(100);
        check("train_underrun_frozen", underrun_cnt, 16'd23);

        // train_req mid-stream with one word still queued.
        wait_cyc(198);
        in_valid = 1'b1; in_data = 16'h00C3;
        expect_word(16'h00C3, 200);
        wait_cyc(199);
        in_data = 16'h0F0F;
        expect_word(16'h0F0F, 265);
        wait_cyc(200);
        in_valid = 1'b0;
        train_req = 1'b1;
        train_q.push_back(64);
        wait_cyc(201);
        train_req = 1'b0;
        check("retrain_done_low", train_done, 1'b0);

        // Long idle stretch: counter must stick at all-ones.
        wait_cyc(66500);
        check("underrun_saturated", underrun_cnt, 16'hFFFF);
        wait_cyc(66505);
        check("underrun_still_sat", underrun_cnt, 16'hFFFF);

        // Asynchronous reset between clock edges with live data on the lanes.
        wait_cyc(66510);
        in_valid = 1'b1; in_data = 16'h00F0;
        expect_word(16'h00F0, 66512);
        wait_cyc(66511);
        in_valid = 1'b0;
        wait_cyc(66512);
        #1 rst_n = 1'b0;
        #1;
        check("async_lane_rise", lane_rise, 8'h00);
        check("async_lane_fall", lane_fall, 8'h00);
        check("async_clk_fwd_en", clk_fwd_en, 1'b0);
        check("async_in_ready", in_ready, 1'b0);
        check("async_train_done", train_done, 1'b0);
        check("async_underrun", underrun_cnt, 16'h0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("train_q_drained", train_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_ddr_tx.md
# lvds_ddr_tx

Transmit-side counterpart of the 8-lane DDR LVDS capture path. Accepts 16-bit sample words over a valid/ready handshake, buffers them in a 2-entry FIFO, and splits each word into even/odd lane bits that feed eight ODDR/OBUFDS pairs plus a forwarded-clock enable. Sends a training pattern after reset and on request so the receiver can align, and fills gaps with an idle pattern. Used as an ADC emulator and for loopback of the capture block.

## Interface
- TRAIN_PATTERN, 16'hA55A, word sent in TRAIN state
- TRAIN_CYCLES, 64, number of TRAIN words (≥1)
- IDLE_PATTERN, 16'h0000, word sent in RUN when the FIFO is empty
- clk  input  1  word clock; one 16-bit word per cycle (DDR on lanes)
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  16  sample word
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO not full
- train_req  input  1  single-cycle pulse; restart training
- lane_rise  output  8  lane i = word bit 2i (rising-edge half)
- lane_fall  output  8  lane i = word bit 2i+1 (falling-edge half)
- clk_fwd_en  output  1  enable for forwarded-clock ODDR
- train_done  output  1  high in RUN
- underrun_cnt  output  16  saturating count of idle-pattern insertions

## Operation
- States: RST → TRAIN → RUN; RUN → TRAIN on train_req.
- RST: entered during rst_n low; left on first clk edge after release.
- TRAIN: output register loads TRAIN_PATTERN each cycle; down-counter from TRAIN_CYCLES−1; at 0 go to RUN. FIFO is not read; writes still accepted while not full.
- RUN: each cycle, FIFO non-empty → pop head into output register; empty → load IDLE_PATTERN, underrun_cnt += 1 (saturates at 16'hFFFF).
- train_req in RUN: next cycle is TRAIN with a full TRAIN_CYCLES count. train_req in TRAIN: counter reloads. FIFO contents preserved in both cases.
- FIFO: 2 entries, pointer-based; in_ready = !full (registered). Write on in_valid && in_ready. Simultaneous push and pop when full: legal only if in_ready was high; in_ready depends on registered occupancy, so no write occurs while full.
- Bit mapping: lane_rise[i] = word[2i], lane_fall[i] = word[2i+1], i = 0..7.
- underrun_cnt clears only on reset.

## Timing
- Reset values: lane_rise = 8'h00, lane_fall = 8'h00, clk_fwd_en = 0, in_ready = 0, train_done = 0, underrun_cnt = 0, FIFO empty, state RST.
- First edge after rst_n release: clk_fwd_en = 1, in_ready = 1, first TRAIN word on lanes.
- TRAIN lasts exactly TRAIN_CYCLES output cycles; train_done rises with the first RUN word.
- Latency: word accepted at edge k with FIFO empty in RUN appears on lanes after edge k+1. Each queued word adds one cycle.
- Sustained throughput: one word per cycle, no bubbles while in_valid stays high in RUN.
- rst_n assertion mid-transfer: all outputs return to reset values immediately (asynchronous); FIFO contents discarded.

## Configuration
- LVDS_TX_PRBS_EN defined: adds input prbs_sel (1 bit). In RUN with prbs_sel = 1, output word is the next PRBS-15 value (x^15+x^14+1, seed 15'h7FFF, 16-bit word = {1'b0, lfsr}, advanced once per cycle); FIFO is not popped, underrun_cnt frozen. LFSR reseeds on reset and on entering TRAIN.
- Undefined: no prbs_sel port, no LFSR logic; RUN behaves as above.

## Test plan
- Reset release, in_valid = 0: 64 cycles of lane_rise = 8'h00? no — TRAIN_PATTERN 16'hA55A gives lane_rise = 8'h3C, lane_fall = 8'hC3 for 64 cycles, then train_done = 1, lanes 8'h00/8'h00, underrun_cnt increments each cycle.
- RUN, stream 16'h0001, 16'hFFFE, 16'h5555 back-to-back: lanes show 8'h01/00, 8'hFE/FF, 8'hFF/00 on consecutive cycles, one cycle after each accept, no idle insertion.
- RUN, FIFO filled with downstream-independent pushes while in TRAIN (3 writes attempted): 2 accepted, in_ready = 0 on third; after TRAIN both words emerge in order.
- train_req pulse mid-stream with 1 word queued: next 64 cycles TRAIN_PATTERN, queued word emerges immediately after, train_done low during TRAIN.
- Hold in RUN with no input for 70000 cycles: underrun_cnt saturates at 16'hFFFF.
- With LVDS_TX_PRBS_EN, prbs_sel = 1: first RUN word 16'h7FFF-derived sequence matches reference LFSR model for 1000 cycles; FIFO occupancy unchanged.
